rr_arbiter_4_1: RTL

//   Round-robin arbiter stage that feeds the 4:1 mux datapath. Four requesters

---
 rtl/rr_arbiter_4_1.sv | 96 +++++++++
 1 files changed

// File: rtl/rr_arbiter_4_1.sv
// Round-robin arbiter for four valid/ready requesters feeding a 4:1 mux,
// with a one-entry registered output stage (data plus source index).
module rr_arbiter_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [3:0]       vld,
    output logic [3:0]       rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]       out_src_q,   out_src_d;
    logic [1:0]       last_grant_q, last_grant_d;

    logic             load;
    logic             any_vld;
    logic             grant;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [WIDTH-1:0] sel_data;

    // Winner search: scan from the farthest position back to ptr so the
    // last hit written is the first requester in round-robin order.
    always_comb begin
        load    = !out_valid_q || out_ready;
        any_vld = |vld;
        ptr     = last_grant_q + 2'd1;
        winner  = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (vld[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end

    // 4:1 data mux steered only by the winner, so unselected inputs never leak.
    always_comb begin
        sel_data = d0;
        case (winner)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            default: sel_data = d3;
        endcase
    end

    // Handshake and output-stage next state; rdy held low while in reset.
    always_comb begin
        grant        = load && any_vld && rst_n;
        rdy          = grant ? (4'b0001 << winner) : 4'b0000;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (any_vld) begin
                out_valid_d  = 1'b1;
                out_data_d   = sel_data;
                out_src_d    = winner;
                last_grant_d = winner;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    // State registers; last_grant resets to 3 so requester 0 is served first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 2'd0;
            last_grant_q <= 2'd3;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
